// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Owns the single write port of the register file and shares it among N
//   write requesters (e.g. ALU writeback, load unit, debug port).
//   After reset it first clears every register to zero, one address per
//   cycle. It then grants at most one request per cycle in round-robin order.
//
// Parameters
//   W  data path width (matches the register file)
//   D  register pointer width, 2**D registers (matches the register file)
//   N  number of write requesters, N >= 2
//
// Ports
//   Clk         clock, all state updates on posedge
//   Reset_n     asynchronous active-low reset
//   Req         Req[i]=1: requester i has a pending write
//   ReqAddr     requester i address in bits [i*D +: D]
//   ReqData     requester i data in bits [i*W +: W]
//   Grant       one-hot, combinational; request i accepted at this edge
//   Busy        high while the post-reset clear runs; no grants while high
//   RegWriteEn  registered write enable to the register file
//   Waddr       registered write address to the register file
//   DataIn      registered write data to the register file
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int N = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [N-1:0]   Req,
  input  logic [N*D-1:0] ReqAddr,
  input  logic [N*W-1:0] ReqData,
  output logic [N-1:0]   Grant,
  output logic           Busy,
  output logic           RegWriteEn,
  output logic [D-1:0]   Waddr,
  output logic [W-1:0]   DataIn
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_s;
  // One extra bit so the end of the clear sweep shows up as the MSB.
  logic [D:0]    clr_cnt_r;
  logic [D:0]    clr_cnt_s;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_s;

  logic          gnt_any_s;
  logic [PW-1:0] gnt_idx_s;
  logic [PW:0]   cand_s;

  logic          wen_s;
  logic [D-1:0]  waddr_s;
  logic [W-1:0]  data_s;

  // The state register resets to CLEAR, so Busy is already high while Reset_n is low.
  assign Busy = (state_r == ST_CLEAR);

  // Round-robin search: visit ptr, ptr+1, ... (mod N) and pick the first active request.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    Grant     = '0;
    if (state_r == ST_ARB) begin
      for (int k = 0; k < N; k++) begin
        cand_s = {1'b0, ptr_r} + (PW+1)'(k);
        if (cand_s >= (PW+1)'(N)) begin
          cand_s = cand_s - (PW+1)'(N);
        end else begin
          cand_s = cand_s;
        end
        for (int i = 0; i < N; i++) begin
          if (!gnt_any_s && Req[i] && (cand_s == (PW+1)'(i))) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = PW'(i);
          end else begin
            gnt_any_s = gnt_any_s;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (gnt_any_s && (gnt_idx_s == PW'(i))) begin
          Grant[i] = 1'b1;
        end else begin
          Grant[i] = 1'b0;
        end
      end
    end else begin
      Grant = '0;
    end
  end

  // Next state, clear counter, pointer and the next register-file write.
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = clr_cnt_r;
    ptr_s     = ptr_r;
    wen_s     = 1'b0;
    waddr_s   = Waddr;
    data_s    = DataIn;
    case (state_r)
      ST_CLEAR: begin
        wen_s     = 1'b1;
        waddr_s   = clr_cnt_r[D-1:0];
        data_s    = '0;
        clr_cnt_s = clr_cnt_r + (D+1)'(1);
        // The MSB sets once the write to the last address has been issued.
        if (clr_cnt_s[D]) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_ARB: begin
        if (gnt_any_s) begin
          wen_s = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (Grant[i]) begin
              waddr_s = ReqAddr[i*D +: D];
              data_s  = ReqData[i*W +: W];
            end else begin
              waddr_s = waddr_s;
            end
          end
          // Explicit wrap so ptr never holds a value >= N.
          if (gnt_idx_s == PW'(N-1)) begin
            ptr_s = '0;
          end else begin
            ptr_s = gnt_idx_s + PW'(1);
          end
        end else begin
          wen_s = 1'b0;
          ptr_s = ptr_r;
        end
      end
      default: begin
        state_s   = ST_CLEAR;
        clr_cnt_s = '0;
        ptr_s     = '0;
      end
    endcase
  end

  // State and output registers; reset also drops any write not yet stored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= '0;
      ptr_r      <= '0;
      RegWriteEn <= 1'b0;
      Waddr      <= '0;
      DataIn     <= '0;
    end else begin
      state_r    <= state_s;
      clr_cnt_r  <= clr_cnt_s;
      ptr_r      <= ptr_s;
      RegWriteEn <= wen_s;
      Waddr      <= waddr_s;
      DataIn     <= data_s;
    end
  end

endmodule
